acc_pingpong_buf: RTL and testbench
===================================

Name: acc_pingpong_buf

Overview:
- Output accumulator between the systolic PE array and the post-processing unit (PPU).
- Accumulates PE-array partial sums (psums) over K reduction passes into 16-row × 16-lane INT24 tiles.
- Once a tile is complete, it starts the PPU and streams the 16 rows, one per cycle, in the PPU's fixed 16-cycle busy window.
- Two banks (ping-pong), so the array fills one tile while the other drains.

Parameters:
LANES, 16, lanes per row (PPU vector width)
ROWS, 16, rows per tile (PPU acc_cnt range)
PSUM_W, 20, signed psum width per lane from the array
ACC_W, 24, signed accumulator width per lane (PPU i_acc_data lane width)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_clear  in  1  sync abort: all banks freed, FSMs idle
i_psum_valid  in  1  psum row beat valid
o_psum_ready  out  1  beat accepted when valid&&ready
i_psum_data  in  PSUM_W*LANES  signed psums, lane k at [k*PSUM_W +: PSUM_W]
i_psum_first  in  1  beat belongs to the first pass (overwrite)
i_psum_last  in  1  beat belongs to the final pass (close tile after row ROWS-1)
o_ppu_start  out  1  one-cycle PPU start pulse
o_acc_data  out  ACC_W*LANES  streamed row to PPU
o_acc_valid  out  1  o_acc_data carries a tile row
o_busy  out  1  any bank not FREE

Behaviour:
- Interface: one clock i_clk; reset i_rst_n asynchronous, active-low.
- Reset: every bank FREE, wr_bank=rd_bank=0, wr_row=rd_row=0, drain FSM D_IDLE.
  - All outputs 0, except o_psum_ready=1 one cycle after reset release.
- Bank state: each bank is one of FREE, FILL, FULL, DRAIN.
- Write side:
  - o_psum_ready = bank[wr_bank] is FREE or FILL.
  - On an accepted beat, write row wr_row of wr_bank; bank goes to FILL; wr_row increments and wraps ROWS-1 -> 0.
  - first=1: mem = sext(psum).
  - first=0: mem = sat(mem + sext(psum)); the sum is computed at ACC_W+1 bits and clipped to [-2^(ACC_W-1), 2^(ACC_W-1)-1] per lane.
  - Accepted beat with wr_row==ROWS-1 and last=1: bank goes to FULL, wr_bank toggles.
  - first and last are sampled per beat. The upstream holds them constant across a pass. first=last=1 is legal (single pass).
- Drain FSM: D_IDLE -> D_START -> D_STREAM -> D_GAP.
  - D_IDLE: if bank[rd_bank]==FULL, go to D_START; bank becomes DRAIN.
  - D_START (1 cycle): o_ppu_start=1.
  - D_STREAM (ROWS cycles): o_acc_valid=1 and o_acc_data = mem[rd_bank][rd_row], read combinationally; rd_row goes 0..ROWS-1. On the last cycle the bank becomes FREE and rd_bank toggles.
  - D_GAP (1 cycle): lets the PPU return to idle. Next state is D_START if the new rd_bank is FULL, else D_IDLE.
  - o_acc_data = 0 outside D_STREAM.
- Latency: row ROWS-1 (last pass) accepted in cycle A.
  - o_ppu_start high in A+2.
  - Rows 0..15 appear in A+3..A+18.
  - Earliest next start pulse is A+20.
- Simultaneous events:
  - A bank freed at the end of D_STREAM is writable in the next cycle; o_psum_ready rises then if wr_bank points to it.
  - A write and a drain never target the same bank, because bank states are exclusive.
- Both banks FULL/DRAIN: o_psum_ready=0. A held beat is not consumed until ready.
- i_clear: same effect as reset, applied at the clock edge. It beats a simultaneous accepted beat (beat dropped) and aborts any stream in progress (o_acc_valid=0 next cycle; the PPU is not notified).
- Async reset mid-stream: outputs go to 0 immediately.

Decomposition:
- Shared package `acc_pkg`:
  - LANES, ROWS, PSUM_W, ACC_W.
  - Bank-state encoding (FREE/FILL/FULL/DRAIN).
  - Drain-state encoding.
  - A saturating-add function (sext + clip).
- Natural sub-module `acc_bank`: one ROWS×(ACC_W*LANES) register array with a write port (overwrite/accumulate select, saturation) and a combinational read port. Instantiated twice.

Test Plan:
- Single pass, first=last=1, psum lane k row r = r*16+k.
  - o_ppu_start high exactly at A+2.
  - At A+3+r, o_acc_data lane k = r*16+k for r=0..15.
  - o_acc_valid high for exactly 16 cycles.
- Three passes, each psum=+5 on all lanes.
  - Every streamed lane = 15.
  - Pass 1 with psum=-3 (first=1) then +1, +1 gives -1.
- Saturation: first pass 2^19-1 in all lanes, then 40 more passes of 2^19-1.
  - Lanes clip at 8388607.
  - With -2^19 repeated, lanes clip at -8388608.
- Ping-pong back-pressure: stream 3 complete single-pass tiles back to back with valid always high.
  - Ready drops after tile 1 completes while tile 0 still drains.
  - Start pulses at A+2, A+20, A+38 (A = cycle tile 0's row 15 accepted).
  - No beat lost; tile order preserved.
- i_clear asserted on cycle A+8 during the stream.
  - o_acc_valid=0 from A+9.
  - o_busy=0 and o_psum_ready=1 at A+9.
  - A following tile starts with wr_row=0.
- Async reset pulse mid-fill (row 7 of a pass): all outputs 0 immediately. After release, a fresh single-pass tile streams correctly.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg: shared sizes, bank/drain state encodings and the saturating accumulate helper
package acc_pkg;
  localparam int LANES = 16;
  localparam int ROWS = 16;
  localparam int PSUM_W = 20;
  localparam int ACC_W = 24;
  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  typedef enum logic [1:0] {B_FREE, B_FILL, B_FULL, B_DRAIN} bank_st_t;
  typedef enum logic [1:0] {D_IDLE, D_START, D_STREAM, D_GAP} drain_st_t;
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [PSUM_W-1:0] p, input logic first);
    logic [ACC_W-1:0] x;
    logic [ACC_W:0] s;
    x = {{(ACC_W - PSUM_W){p[PSUM_W-1]}}, p};
    s = {a[ACC_W-1], a} + {x[ACC_W-1], x};
    return first ? x : (s[ACC_W] != s[ACC_W-1]) ? {s[ACC_W], {(ACC_W - 1){~s[ACC_W]}}} : s[ACC_W-1:0];
  endfunction
endpackage

// File: rtl/acc_pingpong_buf_if.sv
// acc_pingpong_buf_if: psum write beats from the PE array and row stream toward the PPU
interface acc_pingpong_buf_if;
  import acc_pkg::*;
  logic i_psum_valid;
  logic o_psum_ready;
  logic [PSUM_W*LANES-1:0] i_psum_data;
  logic i_psum_first;
  logic i_psum_last;
  logic o_ppu_start;
  logic [ACC_W*LANES-1:0] o_acc_data;
  logic o_acc_valid;
  logic o_busy;
  modport master (
    output i_psum_valid, i_psum_data, i_psum_first, i_psum_last,
    input o_psum_ready, o_ppu_start, o_acc_data, o_acc_valid, o_busy
  );
  modport slave (
    input i_psum_valid, i_psum_data, i_psum_first, i_psum_last,
    output o_psum_ready, o_ppu_start, o_acc_data, o_acc_valid, o_busy
  );
endinterface

// File: rtl/acc_bank.sv
// acc_bank: one tile of ROWS accumulator rows with overwrite/saturating-accumulate write and combinational read
module acc_bank
  import acc_pkg::*;
(
  input logic i_clk,
  input logic i_we,
  input logic i_first,
  input logic [RW-1:0] i_waddr,
  input logic [PSUM_W*LANES-1:0] i_wdata,
  input logic [RW-1:0] i_raddr,
  output logic [ACC_W*LANES-1:0] o_rdata
);
  logic [ACC_W*LANES-1:0] mem [ROWS];
  logic [ACC_W*LANES-1:0] nxt;
  always_comb begin
    nxt = '0;
    for (int k = 0; k < LANES; k++)
      nxt[k*ACC_W +: ACC_W] = sat_add(mem[i_waddr][k*ACC_W +: ACC_W], i_wdata[k*PSUM_W +: PSUM_W], i_first);
  end
  always_ff @(posedge i_clk)
    if (i_we) mem[i_waddr] <= nxt;
  assign o_rdata = mem[i_raddr];
endmodule

// File: rtl/acc_pingpong_buf.sv
// acc_pingpong_buf: two-bank psum accumulator that fills one tile while streaming the other to the PPU
module acc_pingpong_buf
  import acc_pkg::*;
(
  input logic i_clk,
  input logic i_rst_n,
  input logic i_clear,
  acc_pingpong_buf_if.slave bus
);
  bank_st_t bst [2];
  drain_st_t ds, dn;
  logic live, wb, rb, acc, wr_done, rd_full, rd_last;
  logic [RW-1:0] wr_row, rd_row;
  logic [ACC_W*LANES-1:0] rd [2];
  assign bus.o_psum_ready = live && (bst[wb] == B_FREE || bst[wb] == B_FILL);
  assign acc = bus.i_psum_valid && bus.o_psum_ready && !i_clear;
  assign wr_done = acc && wr_row == LAST_ROW && bus.i_psum_last;
  assign rd_full = bst[rb] == B_FULL;
  assign rd_last = ds == D_STREAM && rd_row == LAST_ROW;
  assign bus.o_ppu_start = ds == D_START;
  assign bus.o_acc_valid = ds == D_STREAM;
  assign bus.o_acc_data = bus.o_acc_valid ? rd[rb] : '0;
  assign bus.o_busy = bst[0] != B_FREE || bst[1] != B_FREE;
  acc_bank u_bank0 (
    .i_clk(i_clk),
    .i_we(acc && !wb),
    .i_first(bus.i_psum_first),
    .i_waddr(wr_row),
    .i_wdata(bus.i_psum_data),
    .i_raddr(rd_row),
    .o_rdata(rd[0])
  );
  acc_bank u_bank1 (
    .i_clk(i_clk),
    .i_we(acc && wb),
    .i_first(bus.i_psum_first),
    .i_waddr(wr_row),
    .i_wdata(bus.i_psum_data),
    .i_raddr(rd_row),
    .o_rdata(rd[1])
  );
  always_comb begin
    dn = ds;
    case (ds)
      D_IDLE, D_GAP: dn = rd_full ? D_START : D_IDLE;
      D_START: dn = D_STREAM;
      D_STREAM: dn = rd_last ? D_GAP : D_STREAM;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) live <= 1'b0;
    else live <= 1'b1;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      bst <= '{B_FREE, B_FREE};
      ds <= D_IDLE;
      wb <= 1'b0;
      rb <= 1'b0;
      wr_row <= '0;
      rd_row <= '0;
    end else if (i_clear) begin
      bst <= '{B_FREE, B_FREE};
      ds <= D_IDLE;
      wb <= 1'b0;
      rb <= 1'b0;
      wr_row <= '0;
      rd_row <= '0;
    end else begin
      ds <= dn;
      if (acc) begin
        wr_row <= wr_row == LAST_ROW ? '0 : wr_row + 1'b1;
        bst[wb] <= wr_done ? B_FULL : B_FILL;
        wb <= wb ^ wr_done;
      end
      if (rd_full && (ds == D_IDLE || ds == D_GAP)) bst[rb] <= B_DRAIN;
      if (ds == D_STREAM) rd_row <= rd_last ? '0 : rd_row + 1'b1;
      if (rd_last) begin
        bst[rb] <= B_FREE;
        rb <= ~rb;
      end
    end
endmodule

// File: tb/tb_acc_pingpong_buf.sv
// tb_acc_pingpong_buf: directed scoreboard bench for the ping-pong accumulator
module tb_acc_pingpong_buf;
  import acc_pkg::*;
  localparam int DW = ACC_W * LANES;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_clear = 1'b0;
  acc_pingpong_buf_if bus();
  acc_pingpong_buf dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .bus(bus));
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int a_cyc = 0;
  int a0 = 0;
  int stalls = 0;
  int wrow = 0;
  int mdl [ROWS][LANES];
  logic [DW-1:0] sbq [$];
  int starts [$];
  int vcycs [$];
  always @(posedge i_clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int qat(input int q[$], input int i);
    return i < q.size() ? q[i] : -1;
  endfunction
  always @(negedge i_clk) begin
    if (bus.o_ppu_start) starts.push_back(cyc);
    if (bus.o_acc_valid) begin
      vcycs.push_back(cyc);
      chk_i("sb_nonempty", int'(sbq.size() != 0), 1);
      if (sbq.size() != 0) chk("row", bus.o_acc_data, sbq.pop_front());
    end
  end
  task automatic send_beat(input logic [PSUM_W*LANES-1:0] d, input logic f, input logic l);
    int n = 0;
    logic [DW-1:0] row;
    bus.i_psum_data = d;
    bus.i_psum_first = f;
    bus.i_psum_last = l;
    bus.i_psum_valid = 1'b1;
    @(negedge i_clk);
    while (!bus.o_psum_ready && n < 100) begin
      n++;
      @(negedge i_clk);
    end
    chk_i("ready_wait", int'(n < 100), 1);
    stalls += n;
    for (int k = 0; k < LANES; k++) begin
      int p;
      int s;
      p = int'($signed(d[k*PSUM_W +: PSUM_W]));
      s = f ? p : mdl[wrow][k] + p;
      mdl[wrow][k] = s > 8388607 ? 8388607 : (s < -8388608 ? -8388608 : s);
    end
    if (wrow == ROWS - 1 && l) begin
      a_cyc = cyc;
      for (int r = 0; r < ROWS; r++) begin
        for (int k = 0; k < LANES; k++) begin
          int v;
          v = mdl[r][k];
          row[k*ACC_W +: ACC_W] = v[ACC_W-1:0];
        end
        sbq.push_back(row);
      end
    end
    wrow = (wrow + 1) % ROWS;
    @(posedge i_clk);
    #1;
  endtask
  task automatic send_pass(input int base, input logic ramp, input logic f, input logic l, input int nrows);
    logic [PSUM_W*LANES-1:0] d;
    for (int r = 0; r < nrows; r++) begin
      for (int k = 0; k < LANES; k++) d[k*PSUM_W +: PSUM_W] = PSUM_W'(base + (ramp ? r * LANES + k : 0));
      send_beat(d, f, l);
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    bus.i_psum_valid = 1'b0;
    while ((bus.o_busy || sbq.size() != 0) && n < 400) begin
      n++;
      @(negedge i_clk);
    end
    chk_i("drain_wait", int'(n < 400), 1);
    @(posedge i_clk);
    #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    bus.i_psum_valid = 1'b0;
    bus.i_psum_data = '0;
    bus.i_psum_first = 1'b0;
    bus.i_psum_last = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_data", bus.o_acc_data, '0);
    chk_i("rst_flags", int'({bus.o_psum_ready, bus.o_ppu_start, bus.o_acc_valid, bus.o_busy}), 0);
    i_rst_n = 1'b1;
    #1;
    chk_i("ready_hold", int'(bus.o_psum_ready), 0);
    @(negedge i_clk);
    chk_i("ready_rise", int'(bus.o_psum_ready), 1);
    @(posedge i_clk);
    #1;
    starts.delete();
    vcycs.delete();
    send_pass(0, 1'b1, 1'b1, 1'b1, 16);
    wait_idle();
    chk_i("t1_nstart", starts.size(), 1);
    chk_i("t1_start", qat(starts, 0), a_cyc + 2);
    chk_i("t1_nvalid", vcycs.size(), 16);
    chk_i("t1_vfirst", qat(vcycs, 0), a_cyc + 3);
    chk_i("t1_vlast", qat(vcycs, 15), a_cyc + 18);
    send_pass(5, 1'b0, 1'b1, 1'b0, 16);
    send_pass(5, 1'b0, 1'b0, 1'b0, 16);
    send_pass(5, 1'b0, 1'b0, 1'b1, 16);
    wait_idle();
    chk_i("acc_15", mdl[3][7], 15);
    send_pass(-3, 1'b0, 1'b1, 1'b0, 16);
    send_pass(1, 1'b0, 1'b0, 1'b0, 16);
    send_pass(1, 1'b0, 1'b0, 1'b1, 16);
    wait_idle();
    chk_i("acc_m1", mdl[9][2], -1);
    send_pass(524287, 1'b0, 1'b1, 1'b0, 16);
    repeat (39) send_pass(524287, 1'b0, 1'b0, 1'b0, 16);
    send_pass(524287, 1'b0, 1'b0, 1'b1, 16);
    wait_idle();
    chk_i("sat_pos", mdl[0][0], 8388607);
    send_pass(-524288, 1'b0, 1'b1, 1'b0, 16);
    repeat (39) send_pass(-524288, 1'b0, 1'b0, 1'b0, 16);
    send_pass(-524288, 1'b0, 1'b0, 1'b1, 16);
    wait_idle();
    chk_i("sat_neg", mdl[15][15], -8388608);
    starts.delete();
    vcycs.delete();
    stalls = 0;
    send_pass(0, 1'b1, 1'b1, 1'b1, 16);
    a0 = a_cyc;
    send_pass(1000, 1'b1, 1'b1, 1'b1, 16);
    send_pass(2000, 1'b1, 1'b1, 1'b1, 16);
    wait_idle();
    chk_i("pp_nstart", starts.size(), 3);
    chk_i("pp_start0", qat(starts, 0), a0 + 2);
    chk_i("pp_start1", qat(starts, 1), a0 + 20);
    chk_i("pp_start2", qat(starts, 2), a0 + 38);
    chk_i("pp_stalls", stalls, 2);
    chk_i("pp_nvalid", vcycs.size(), 48);
    starts.delete();
    vcycs.delete();
    send_pass(0, 1'b1, 1'b1, 1'b1, 16);
    bus.i_psum_valid = 1'b0;
    while (cyc < a_cyc + 8) begin
      @(posedge i_clk);
      #1;
    end
    i_clear = 1'b1;
    @(posedge i_clk);
    #1;
    i_clear = 1'b0;
    sbq.delete();
    wrow = 0;
    @(negedge i_clk);
    chk_i("clr_valid", int'(bus.o_acc_valid), 0);
    chk_i("clr_busy", int'(bus.o_busy), 0);
    chk_i("clr_ready", int'(bus.o_psum_ready), 1);
    chk_i("clr_nvalid", vcycs.size(), 6);
    @(posedge i_clk);
    #1;
    starts.delete();
    vcycs.delete();
    send_pass(300, 1'b1, 1'b1, 1'b1, 16);
    wait_idle();
    chk_i("clr_next_start", qat(starts, 0), a_cyc + 2);
    chk_i("clr_next_nvalid", vcycs.size(), 16);
    send_pass(0, 1'b1, 1'b1, 1'b1, 7);
    bus.i_psum_valid = 1'b1;
    #2;
    chk_i("fill_busy", int'(bus.o_busy), 1);
    i_rst_n = 1'b0;
    #1;
    chk("arst_data", bus.o_acc_data, '0);
    chk_i("arst_flags", int'({bus.o_psum_ready, bus.o_ppu_start, bus.o_acc_valid, bus.o_busy}), 0);
    bus.i_psum_valid = 1'b0;
    wrow = 0;
    sbq.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    starts.delete();
    vcycs.delete();
    send_pass(700, 1'b1, 1'b1, 1'b1, 16);
    wait_idle();
    chk_i("arst_next_start", qat(starts, 0), a_cyc + 2);
    chk_i("arst_next_nvalid", vcycs.size(), 16);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
